seg7_scan_driver: RTL and testbench

Time-multiplexed seven-segment display driver sitting directly downstream of the binary-to-BCD converter in the calculator datapath. It latches a packed BCD result and a sign flag on a one-cycle valid strobe (wired to the converter's `done`). It continuously scans NUM_POS = DECIMAL_DIGITS+1 display positions, applying leading-zero blanking and a floating minus sign. It drives active-low anode and cathode lines of the board's common-anode display.

---
 rtl/calc_pkg.sv | 21 ++
 rtl/seg7_decode.sv | 27 ++
 rtl/seg7_scan_driver.sv | 138 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator constants: active-low seven-segment patterns ordered {g,f,e,d,c,b,a}
// and the default display refresh divider.
package calc_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_ERR   = 7'b0000110;

  localparam int REFRESH_DIV_DEFAULT = 100000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern; non-decimal codes show "E".
module seg7_decode
  import calc_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  // Digit lookup
  always_comb begin
    o_seg = SEG_ERR;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a common-anode seven-segment display with
// leading-zero blanking and a floating minus sign placed just left of the top digit.
module seg7_scan_driver
  import calc_pkg::*;
#(
  parameter int DECIMAL_DIGITS = 7,
  parameter int REFRESH_DIV    = REFRESH_DIV_DEFAULT
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DECIMAL_DIGITS*4-1:0]   i_bcd,
  input  logic                          i_neg,
  input  logic                          i_valid,
  input  logic                          i_clear,
  output logic [DECIMAL_DIGITS:0]       o_an,
  output logic [6:0]                    o_seg,
  output logic                          o_dp
);

  localparam int NUM_POS = DECIMAL_DIGITS + 1;
  localparam int POS_W   = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;
  localparam int PRE_W   = $clog2(REFRESH_DIV);

  logic [PRE_W-1:0]              r_pre;
  logic [POS_W-1:0]              r_pos;
  logic [DECIMAL_DIGITS*4-1:0]   r_disp_bcd;
  logic                          r_disp_neg;
  logic [NUM_POS-1:0]            r_an;
  logic [6:0]                    r_seg;
  logic                          r_dp;

  logic [POS_W-1:0]              w_msd;
  logic [POS_W:0]                w_msd_p1;
  logic                          w_nonzero;
  logic [3:0]                    w_digit;
  logic [6:0]                    w_dec;
  logic [6:0]                    w_seg_next;
  logic [NUM_POS-1:0]            w_an_next;

  // Prescaler and scan position
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pre <= '0;
      r_pos <= '0;
    end else if (r_pre == PRE_W'(REFRESH_DIV - 1)) begin
      r_pre <= '0;
      if (r_pos == POS_W'(NUM_POS - 1)) begin
        r_pos <= '0;
      end else begin
        r_pos <= r_pos + POS_W'(1);
      end
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // Display register; clear has priority over a simultaneous load
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_disp_bcd <= '0;
      r_disp_neg <= 1'b0;
    end else if (i_clear) begin
      r_disp_bcd <= '0;
      r_disp_neg <= 1'b0;
    end else if (i_valid) begin
      r_disp_bcd <= i_bcd;
      r_disp_neg <= i_neg;
    end else begin
      r_disp_bcd <= r_disp_bcd;
      r_disp_neg <= r_disp_neg;
    end
  end

  // Highest nonzero digit (codes above 9 count as nonzero)
  always_comb begin
    w_msd     = '0;
    w_nonzero = 1'b0;
    for (int k = 0; k < DECIMAL_DIGITS; k++) begin
      if (r_disp_bcd[4*k +: 4] != 4'd0) begin
        w_msd     = POS_W'(k);
        w_nonzero = 1'b1;
      end else begin
        w_msd     = w_msd;
        w_nonzero = w_nonzero;
      end
    end
    w_msd_p1 = {1'b0, w_msd} + (POS_W+1)'(1);
  end

  // Digit under the scan and its anode pattern; the sign-only position selects digit 0
  always_comb begin
    w_digit   = 4'd0;
    w_an_next = '1;
    for (int k = 0; k < NUM_POS; k++) begin
      w_an_next[k] = (r_pos != POS_W'(k));
      if ((k < DECIMAL_DIGITS) && (r_pos == POS_W'(k))) begin
        w_digit = r_disp_bcd[4*k +: 4];
      end else begin
        w_digit = w_digit;
      end
    end
  end

  seg7_decode u_decode (
    .i_digit (w_digit),
    .o_seg   (w_dec)
  );

  // Blanking and minus placement; negative zero falls through to a plain "0"
  always_comb begin
    w_seg_next = SEG_BLANK;
    if (r_pos <= w_msd) begin
      w_seg_next = w_dec;
    end else if (({1'b0, r_pos} == w_msd_p1) && r_disp_neg && w_nonzero) begin
      w_seg_next = SEG_MINUS;
    end else begin
      w_seg_next = SEG_BLANK;
    end
  end

  // Output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
      r_dp  <= 1'b1;
    end
  end

  assign o_an  = r_an;
  assign o_seg = r_seg;
  assign o_dp  = r_dp;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver against a digit-string display model.
module tb_seg7_scan_driver;

  localparam int DIG = 7;
  localparam int DIV = 4;
  localparam int NP  = DIG + 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [27:0]   i_bcd = '0;
  logic          i_neg = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_clear = 1'b0;
  logic [7:0]    o_an;
  logic [6:0]    o_seg;
  logic          o_dp;

  int            cyc = 0;
  logic [27:0]   m_bcd = '0;
  logic          m_neg = 1'b0;
  int            vectors = 0;
  int            miscompares = 0;

  seg7_scan_driver #(.DECIMAL_DIGITS(DIG), .REFRESH_DIV(DIV)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .i_bcd   (i_bcd),
    .i_neg   (i_neg),
    .i_valid (i_valid),
    .i_clear (i_clear),
    .o_an    (o_an),
    .o_seg   (o_seg),
    .o_dp    (o_dp)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0000110;
    endcase
  endfunction

  // Number shown = significant digits (at least one), then "-" if negative and nonzero.
  function automatic logic [6:0] ref_seg(input int p, input logic [27:0] bcd, input logic neg);
    int ndig;
    ndig = 1;
    for (int k = 0; k < DIG; k++) if (bcd[4*k +: 4] != 4'd0) ndig = k + 1;
    if (p < ndig) return glyph(bcd[4*p +: 4]);
    if (p == ndig && neg && bcd != 28'd0) return 7'b0111111;
    return 7'h7F;
  endfunction

  // Applies one cycle of inputs and returns what the outputs must show after that edge.
  task automatic drive(input logic [27:0] bcd, input logic neg, input logic valid,
                       input logic clear, output logic [7:0] ea, output logic [6:0] es);
    int p;
    @(negedge CLK);
    i_bcd = bcd; i_neg = neg; i_valid = valid; i_clear = clear;
    p  = (cyc / DIV) % NP;
    es = ref_seg(p, m_bcd, m_neg);
    ea = ~(8'd1 << p);
    @(posedge CLK);
    #1;
    cyc = cyc + 1;
    if (clear) begin
      m_bcd = '0; m_neg = 1'b0;
    end else if (valid) begin
      m_bcd = bcd; m_neg = neg;
    end
  endtask

  task automatic release_reset();
    i_valid = 1'b0; i_clear = 1'b0; i_bcd = '0; i_neg = 1'b0;
    RST = 1'b0;
    cyc = 0; m_bcd = '0; m_neg = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] ea; logic [6:0] es;
    for (int i = 0; i < 9; i++) drive(28'h1234567, 1'b1, 1'b1, 1'b0, ea, es);
    #3; RST = 1'b1; #1;
    vectors++;
    if (o_an !== 8'hFF || o_seg !== 7'h7F || o_dp !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_async an=%h seg=%b dp=%b want an=ff seg=1111111 dp=1", o_an, o_seg, o_dp);
    end
    @(posedge CLK); #1;
    vectors++;
    if (o_an !== 8'hFF || o_seg !== 7'h7F || o_dp !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_held an=%h seg=%b dp=%b want an=ff seg=1111111 dp=1", o_an, o_seg, o_dp);
    end
    #1; release_reset();
    drive(28'h0, 1'b0, 1'b0, 1'b0, ea, es);
    vectors++;
    if (o_an !== 8'hFE || o_seg !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_first an=%h seg=%b want an=fe seg=1000000", o_an, o_seg);
    end
    for (int i = 0; i < 40; i++) begin
      drive(28'h0, 1'b0, 1'b0, 1'b0, ea, es);
      vectors++;
      if (o_an !== ea || o_seg !== es || o_dp !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_scan cyc=%0d an=%h seg=%b want an=%h seg=%b", cyc, o_an, o_seg, ea, es);
      end
    end
  endtask

  task automatic test_pattern(input string name, input logic [27:0] bcd, input logic neg, input int n);
    logic [7:0] ea; logic [6:0] es;
    for (int i = 0; i < n; i++) begin
      drive(bcd, neg, (i == 0), 1'b0, ea, es);
      vectors++;
      if (o_an !== ea) begin
        miscompares++;
        $display("FAIL %s_an cyc=%0d got %h want %h", name, cyc, o_an, ea);
      end
      vectors++;
      if (o_seg !== es || o_dp !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_seg cyc=%0d got %b dp=%b want %b dp=1", name, cyc, o_seg, o_dp, es);
      end
    end
  endtask

  task automatic test_minus_position();
    logic [7:0] ea; logic [6:0] es;
    int seen;
    seen = 0;
    drive(28'h9999999, 1'b1, 1'b1, 1'b0, ea, es);
    for (int i = 0; i < 2 * NP * DIV; i++) begin
      drive(28'h0, 1'b0, 1'b0, 1'b0, ea, es);
      if (o_an == 8'h7F) begin
        seen++;
        vectors++;
        if (o_seg !== 7'b0111111) begin
          miscompares++;
          $display("FAIL minus_pos7 got %b want 0111111", o_seg);
        end
      end
    end
    vectors++;
    if (seen !== 2 * DIV) begin
      miscompares++;
      $display("FAIL pos7_dwell got %0d cycles want %0d", seen, 2 * DIV);
    end
  endtask

  task automatic test_clear_valid();
    logic [7:0] ea; logic [6:0] es;
    test_pattern("preclear", 28'h1234567, 1'b1, 11);
    drive(28'h0000005, 1'b0, 1'b1, 1'b1, ea, es);
    for (int i = 0; i < 40; i++) begin
      drive(28'h0, 1'b0, 1'b0, 1'b0, ea, es);
      vectors++;
      if (o_an !== ea || o_seg !== es) begin
        miscompares++;
        $display("FAIL clear_valid cyc=%0d an=%h seg=%b want an=%h seg=%b", cyc, o_an, o_seg, ea, es);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ea; logic [6:0] es;
    logic [27:0] v;
    for (int i = 0; i < 10; i++) begin
      v = 28'($urandom_range(0, 9)) << (4 * (i % DIG));
      drive(v, i[0], 1'b1, 1'b0, ea, es);
      vectors++;
      if (o_an !== ea || o_seg !== es) begin
        miscompares++;
        $display("FAIL b2b_load i=%0d an=%h seg=%b want an=%h seg=%b", i, o_an, o_seg, ea, es);
      end
    end
    for (int i = 0; i < 36; i++) begin
      drive(28'h0, 1'b0, 1'b0, 1'b0, ea, es);
      vectors++;
      if (o_an !== ea || o_seg !== es) begin
        miscompares++;
        $display("FAIL b2b_hold cyc=%0d an=%h seg=%b want an=%h seg=%b", cyc, o_an, o_seg, ea, es);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] ea; logic [6:0] es;
    logic [27:0] v;
    int nd;
    for (int i = 0; i < 600; i++) begin
      nd = $urandom_range(0, DIG);
      v  = '0;
      for (int k = 0; k < nd; k++)
        v[4*k +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      drive(v, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 31) == 0), ea, es);
      vectors++;
      if (o_an !== ea || o_seg !== es || o_dp !== 1'b1) begin
        miscompares++;
        $display("FAIL random cyc=%0d an=%h seg=%b dp=%b want an=%h seg=%b dp=1",
                 cyc, o_an, o_seg, o_dp, ea, es);
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #2; release_reset();
    test_reset();
    test_pattern("full_load", 28'h1234567, 1'b0, 2 * NP * DIV + 4);
    test_pattern("sign", 28'h0000042, 1'b1, NP * DIV + 4);
    test_pattern("neg_zero", 28'h0000000, 1'b1, NP * DIV + 4);
    test_pattern("nine_neg", 28'h9999999, 1'b1, NP * DIV + 4);
    test_pattern("invalid", 28'h00000A0, 1'b0, NP * DIV + 4);
    test_minus_position();
    test_clear_valid();
    test_back_to_back();
    test_random();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
